display_mux: RTL and testbench

- Time-multiplexes two 4-bit hex digits onto the single shared `seg_display` decoder input.
- Drives two active-low anode enables for the dual common-anode seven-segment module.
- Sits directly upstream of `seg_display`: output `s` feeds its `s` input, and `an0_n`/`an1_n` drive the PNP anode transistors.
- Provides flicker-free refresh at roughly 1 kHz per digit from the 48 MHz system clock.

---
 rtl/display_pkg.sv | 23 ++
 rtl/slot_timer.sv | 47 ++++
 rtl/display_mux.sv | 129 ++++++++++++
 tb/tb_display_mux.sv | 131 +++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the two-digit display multiplexer.
//   mux_state_t       - refresh sequencer states (GAP0/GAP1 used only with
//                       DISPLAY_DEAD_TIME_EN)
//   ANODE_ON/OFF      - anode enable levels for the PNP drivers (active low)
//   SLOT_CYCLES_DEF   - default lit time per digit at 48 MHz (~1 kHz per digit)
//   BLANK_CYCLES_DEF  - default dead time between digits
package display_pkg;

  typedef enum logic [2:0] {
    OFF  = 3'd0,
    DIG0 = 3'd1,
    GAP0 = 3'd2,
    DIG1 = 3'd3,
    GAP1 = 3'd4
  } mux_state_t;

  localparam logic ANODE_ON  = 1'b0;
  localparam logic ANODE_OFF = 1'b1;

  localparam int SLOT_CYCLES_DEF  = 24000;
  localparam int BLANK_CYCLES_DEF = 480;

endpackage

// File: rtl/slot_timer.sv
// slot_timer: up-counter timing one display slot or gap.
//   clk     - system clock
//   reset_n - asynchronous active-low reset (count to 0)
//   clr     - synchronous clear, asserted on every state entry
//   limit   - length of the current interval in cycles (>= 1)
//   done    - high while the count sits on its terminal value limit-1
// The counter stops on the terminal value instead of wrapping, so a held
// state never sees a spurious second terminal count.
module slot_timer
  import display_pkg::*;
#(
  parameter int CNT_W = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clr,
  input  logic [CNT_W:0] limit,
  output logic           done
);

  localparam logic [CNT_W:0]   LIM_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   last;

  assign last = limit - LIM_ONE;
  assign done = ({1'b0, cnt_q} == last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (!done) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_mux.sv
// display_mux: time-multiplexes two hex digits onto one seg_display decoder
// and drives the two active-low common-anode enables.
//   clk        - 48 MHz system clock
//   reset_n    - asynchronous active-low reset
//   s0, s1     - hex values for digit 0 (left) and digit 1 (right)
//   s          - hex value presented to seg_display (registered)
//   an0_n      - digit 0 anode enable, low = lit (registered)
//   an1_n      - digit 1 anode enable, low = lit (registered)
//   frame_tick - one-cycle pulse on the first cycle of each new frame
// Optional build macro DISPLAY_DEAD_TIME_EN inserts BLANK_CYCLES of all-off
// time after each digit to hide transistor turn-off ghosting.
module display_mux
  import display_pkg::*;
#(
  parameter int SLOT_CYCLES  = SLOT_CYCLES_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [3:0] s,
  output logic       an0_n,
  output logic       an1_n,
  output logic       frame_tick
);

  localparam int CNT_MAX = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX <= 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W:0] SLOT_LIM  = (CNT_W+1)'(SLOT_CYCLES);
  localparam logic [CNT_W:0] BLANK_LIM = (CNT_W+1)'(BLANK_CYCLES);

  mux_state_t     state_q, state_d;
  logic [3:0]     s_q, s_d;
  logic           an0_n_q, an0_n_d;
  logic           an1_n_q, an1_n_d;
  logic           frame_tick_q, frame_tick_d;
  logic           entering;
  logic           done;
  logic [CNT_W:0] limit;

  // Gaps use the blank length; everything else (including OFF) the slot length.
  assign limit    = (state_q == GAP0 || state_q == GAP1) ? BLANK_LIM : SLOT_LIM;
  assign entering = (state_d != state_q);

  slot_timer #(
    .CNT_W(CNT_W)
  ) u_slot_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (entering),
    .limit  (limit),
    .done   (done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OFF: state_d = DIG0;
`ifdef DISPLAY_DEAD_TIME_EN
      DIG0: if (done) state_d = GAP0;
      GAP0: if (done) state_d = DIG1;
      DIG1: if (done) state_d = GAP1;
      GAP1: if (done) state_d = DIG0;
`else
      DIG0: if (done) state_d = DIG1;
      DIG1: if (done) state_d = DIG0;
      GAP0: state_d = DIG1;
      GAP1: state_d = DIG0;
`endif
      default: state_d = OFF;
    endcase
  end

  // Outputs change only on state entry, so digit inputs are sampled exactly
  // once per slot and mid-slot changes wait for the next entry.
  always_comb begin
    s_d          = s_q;
    an0_n_d      = an0_n_q;
    an1_n_d      = an1_n_q;
    frame_tick_d = 1'b0;
    if (entering) begin
      unique case (state_d)
        DIG0: begin
          s_d          = s0;
          an0_n_d      = ANODE_ON;
          an1_n_d      = ANODE_OFF;
          frame_tick_d = (state_q == DIG1) || (state_q == GAP1);
        end
        DIG1: begin
          s_d     = s1;
          an0_n_d = ANODE_OFF;
          an1_n_d = ANODE_ON;
        end
        GAP0, GAP1: begin
          an0_n_d = ANODE_OFF;
          an1_n_d = ANODE_OFF;
        end
        default: begin
          an0_n_d = ANODE_OFF;
          an1_n_d = ANODE_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= OFF;
      s_q          <= 4'h0;
      an0_n_q      <= ANODE_OFF;
      an1_n_q      <= ANODE_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      an0_n_q      <= an0_n_d;
      an1_n_q      <= an1_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign s          = s_q;
  assign an0_n      = an0_n_q;
  assign an1_n      = an1_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_mux.sv
// tb_display_mux: directed bench for display_mux with SLOT_CYCLES=4 and
// BLANK_CYCLES=2. Outputs are sampled on the falling clock edge and packed
// as {an0_n, an1_n, s, frame_tick}. Gap expectations follow
// DISPLAY_DEAD_TIME_EN.
module tb_display_mux;

`ifdef DISPLAY_DEAD_TIME_EN
  localparam int GAP_N = 2;
`else
  localparam int GAP_N = 0;
`endif

  logic       clk;
  logic       reset_n;
  logic [3:0] s0;
  logic [3:0] s1;
  logic [3:0] s;
  logic       an0_n;
  logic       an1_n;
  logic       frame_tick;

  int errs   = 0;
  int checks = 0;

  display_mux #(
    .SLOT_CYCLES (4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s0        (s0),
    .s1        (s1),
    .s         (s),
    .an0_n     (an0_n),
    .an1_n     (an1_n),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] obs();
    return {an0_n, an1_n, s, frame_tick};
  endfunction

  // n lit cycles of one digit; only the first may carry frame_tick.
  task automatic slot(input string tag, input logic a0, input logic a1,
                      input logic [3:0] sv, input logic ft1, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, 32'(obs()), 32'({a0, a1, sv, (i == 0) ? ft1 : 1'b0}));
    end
  endtask

  task automatic gap(input string tag, input logic [3:0] held);
    for (int i = 0; i < GAP_N; i++) begin
      @(negedge clk);
      check(tag, 32'(obs()), 32'({1'b1, 1'b1, held, 1'b0}));
    end
  endtask

  // Both anodes must never be lit together.
  always @(negedge clk) check("anode_excl", 32'(an0_n | an1_n), 32'd1);

  initial begin
    logic [7:0] kv;
    logic [3:0] cur0;
    reset_n = 1'b0;
    s0      = 4'hA;
    s1      = 4'hC;

    // Reset held for three edges
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'(obs()), 32'({1'b1, 1'b1, 4'h0, 1'b0}));
    reset_n = 1'b1;

    // First DIG0 after release: lit on the first edge, no frame_tick
    slot("first_dig0", 1'b0, 1'b1, 4'hA, 1'b0, 4);
    gap("gap0_a", 4'hA);
    s0 = 4'h3;
    slot("dig1_c", 1'b1, 1'b0, 4'hC, 1'b0, 4);
    gap("gap1_c", 4'hC);

    // Steady frame with s0=3; change s0 to 7 on the 2nd DIG0 cycle
    slot("dig0_3_head", 1'b0, 1'b1, 4'h3, 1'b1, 2);
    s0 = 4'h7;
    slot("dig0_3_hold", 1'b0, 1'b1, 4'h3, 1'b0, 2);
    gap("gap0_3", 4'h3);
    slot("dig1_c2", 1'b1, 1'b0, 4'hC, 1'b0, 4);
    gap("gap1_c2", 4'hC);
    slot("dig0_7", 1'b0, 1'b1, 4'h7, 1'b1, 4);
    gap("gap0_7", 4'h7);

    // Async reset in the middle of DIG1, between edges
    slot("dig1_pre_rst", 1'b1, 1'b0, 4'hC, 1'b0, 2);
    #2 reset_n = 1'b0;
    #1 check("async_reset", 32'(obs()), 32'({1'b1, 1'b1, 4'h0, 1'b0}));
    s0 = 4'hE;
    @(negedge clk);
    reset_n = 1'b1;
    slot("restart_dig0", 1'b0, 1'b1, 4'hE, 1'b0, 1);
    cur0 = 4'hE;

    // Sweep all digit pairs; each loop starts on the first DIG0 cycle
    for (int k = 0; k < 256; k++) begin
      kv = 8'(k);
      s1 = kv[3:0];
      slot("sweep_dig0", 1'b0, 1'b1, cur0, 1'b0, 3);
      gap("sweep_gap0", cur0);
      slot("sweep_dig1_in", 1'b1, 1'b0, kv[3:0], 1'b0, 1);
      s0 = kv[7:4];
      slot("sweep_dig1", 1'b1, 1'b0, kv[3:0], 1'b0, 3);
      gap("sweep_gap1", kv[3:0]);
      slot("sweep_dig0_in", 1'b0, 1'b1, kv[7:4], 1'b1, 1);
      cur0 = kv[7:4];
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
